// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_pkg
//  Description : Shared encodings for the fetch sequencer: branch-select
//                codes, MUX C select values, fetch FSM states and the
//                branch-decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    // Branch select (BS) encodings presented by the execute stage
    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JREG = 2'b10;
    localparam logic [1:0] BS_JMP  = 2'b11;

    // MUX C select values driven back to the PC source mux
    localparam logic [1:0] SEL_PC1 = 2'd0;
    localparam logic [1:0] SEL_BRA = 2'd1;
    localparam logic [1:0] SEL_RAA = 2'd2;

    typedef enum logic [0:0] {
        FETCH    = 1'b0,
        REDIRECT = 1'b1
    } fetch_state_t;

    // Resolve BS/PS/Z into a MUX C select; a conditional branch is taken
    // when the zero flag equals the requested polarity.
    function automatic logic [1:0] branch_sel(input logic [1:0] bs,
                                              input logic       ps,
                                              input logic       z);
        logic [1:0] sel;
        case (bs)
            BS_NONE: sel = SEL_PC1;
            BS_COND: sel = (z == ps) ? SEL_BRA : SEL_PC1;
            BS_JREG: sel = SEL_RAA;
            BS_JMP:  sel = SEL_BRA;
            default: sel = SEL_PC1;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bundle of the branch-resolution, decode-handshake and
//                instruction-memory signals of the fetch sequencer. The
//                master modport is the sequencer itself; slave is its
//                environment (execute, decode and instruction memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int W  = 16,
    parameter int IW = 32
);
    logic          BR_VALID;
    logic [1:0]    BS;
    logic          PS;
    logic          Z;
    logic [W-1:0]  BrA;
    logic [W-1:0]  RAA;
    logic          STALL;
    logic          IMEM_ACK;
    logic [IW-1:0] IMEM_DATA;
    logic          IMEM_REQ;
    logic [W-1:0]  IMEM_ADDR;
    logic [IW-1:0] IR_OUT;
    logic          IR_VALID;
    logic [W-1:0]  PC_1;
    logic [1:0]    MUX_C_SEL;
    logic          FLUSH;

    modport master (
        input  BR_VALID, BS, PS, Z, BrA, RAA, STALL, IMEM_ACK, IMEM_DATA,
        output IMEM_REQ, IMEM_ADDR, IR_OUT, IR_VALID, PC_1, MUX_C_SEL, FLUSH
    );

    modport slave (
        output BR_VALID, BS, PS, Z, BrA, RAA, STALL, IMEM_ACK, IMEM_DATA,
        input  IMEM_REQ, IMEM_ADDR, IR_OUT, IR_VALID, PC_1, MUX_C_SEL, FLUSH
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Two-deep shift FIFO. Entry 0 is always the head, so the
//                head is a plain register output. Supports simultaneous
//                push and pop, and a clear that wins over both.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DW = 48
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clear_i,
    input  wire logic          push_i,
    input  wire logic          pop_i,
    input  wire logic [DW-1:0] data_i,
    output logic [DW-1:0]      data_o,
    output logic [1:0]         count_o,
    output logic               valid_o
);
    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic [1:0]    count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    // Guard against pops when empty and pushes that would overflow
    always_comb begin
        pop_ok  = pop_i & (count_q != 2'd0);
        push_ok = push_i & ((count_q != 2'd2) | pop_ok);
    end

    // Next entry contents and occupancy
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = data_i;
                    else                 ent1_d = data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind
                    // whatever survives the pop.
                    if (count_q == 2'd2) begin
                        ent0_d = ent1_q;
                        ent1_d = data_i;
                    end else begin
                        ent0_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign data_o  = ent0_q;
    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch and next-PC controller. Owns the PC,
//                issues one outstanding instruction-memory request at a time,
//                buffers up to two fetched words for decode and redirects the
//                PC on taken branches, flushing wrong-path work.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int           W            = 16,
    parameter int           IW           = 32,
    parameter logic [W-1:0] RESET_VECTOR = '0
) (
    input  wire logic            CLOCK,
    input  wire logic            RESET,
    fetch_sequencer_if.master    bus
);
    localparam int           QW  = IW + W;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    fetch_state_t  state_q, state_d;
    logic [W-1:0]  pc_q, pc_d;
    logic [W-1:0]  addr_q, addr_d;
    logic          req_q, req_d;
    logic          flush_q, flush_d;

    logic [1:0]    sel;
    logic [W-1:0]  target;
    logic          taken;
    logic          ack_acc;
    logic          pop;
    logic          push;
    logic          launch;
    logic [1:0]    q_count;
    logic [1:0]    count_after;
    logic          q_valid;
    logic [QW-1:0] q_head;
    logic [QW-1:0] q_din;

    // Branch decode into the MUX C select; forced to PC+1 during reset
    always_comb begin
        sel = SEL_PC1;
        if (!RESET && bus.BR_VALID) begin
            sel = branch_sel(bus.BS, bus.PS, bus.Z);
        end
        target = (sel == SEL_RAA) ? bus.RAA : bus.BrA;
        taken  = bus.BR_VALID & (sel != SEL_PC1);
    end

    // Handshake qualifiers: ACKs only count with a request outstanding,
    // and wrong-path data (taken now, or REDIRECT) is never queued.
    always_comb begin
        ack_acc     = bus.IMEM_ACK & req_q;
        pop         = q_valid & ~bus.STALL & ~taken;
        push        = ack_acc & (state_q == FETCH) & ~taken;
        count_after = q_count - {1'b0, pop};
        launch      = (state_q == FETCH) & ~req_q & ~taken & (count_after < 2'd2);
        q_din       = {bus.IMEM_DATA, addr_q + ONE};
    end

    // Next PC, request, flush and FSM state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        flush_d = 1'b0;

        if (taken) begin
            pc_d    = target;
            flush_d = 1'b1;
        end else if (launch) begin
            pc_d   = pc_q + ONE;
            addr_d = pc_q;
        end

        if (ack_acc) begin
            req_d = 1'b0;
        end else if (launch) begin
            req_d = 1'b1;
        end

        case (state_q)
            FETCH: begin
                // An unanswered request must drain before refetching
                if (taken && req_q && !ack_acc) state_d = REDIRECT;
            end
            REDIRECT: begin
                if (ack_acc) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            addr_q  <= '0;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            flush_q <= flush_d;
        end
    end

    fetch_queue #(
        .DW (QW)
    ) u_queue (
        .clk     (CLOCK),
        .rst     (RESET),
        .clear_i (taken),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (q_din),
        .data_o  (q_head),
        .count_o (q_count),
        .valid_o (q_valid)
    );

    assign bus.IMEM_REQ  = req_q;
    assign bus.IMEM_ADDR = addr_q;
    assign bus.IR_OUT    = q_head[QW-1:W];
    assign bus.PC_1      = q_head[W-1:0];
    assign bus.IR_VALID  = q_valid;
    assign bus.MUX_C_SEL = sel;
    assign bus.FLUSH     = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer. A 16-bit
//                instance covers fetch, stall, branch and redirect cases; a
//                4-bit instance covers PC wrap and reset mid-request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst4 = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.W(16), .IW(32)) bus ();
    fetch_sequencer_if #(.W(4),  .IW(32)) bus4 ();

    fetch_sequencer #(.W(16), .IW(32), .RESET_VECTOR(16'h0000)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    fetch_sequencer #(.W(4), .IW(32), .RESET_VECTOR(4'hE)) dut4 (
        .CLOCK (clk),
        .RESET (rst4),
        .bus   (bus4)
    );

    // Combinational branch-decode vectors: {BR_VALID, BS, PS, Z} -> sel
    logic [4:0] dec_in  [7] = '{5'b1_00_0_0, 5'b1_01_1_1, 5'b1_01_0_0,
                                5'b1_01_1_0, 5'b1_10_0_1, 5'b1_11_0_0,
                                5'b0_11_1_1};
    logic [1:0] dec_exp [7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.BR_VALID = 1'b0; bus.BS = 2'b00; bus.PS = 1'b0; bus.Z = 1'b0;
        bus.BrA = '0; bus.RAA = '0; bus.STALL = 1'b0;
        bus.IMEM_ACK = 1'b0; bus.IMEM_DATA = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.BR_VALID = 1'b1;
        bus.BS = 2'b11;
        step();
        #1;
        checks++; if (bus.MUX_C_SEL !== 2'd0) $display("FAIL reset_sel: got %0d want 0", bus.MUX_C_SEL); else passed++;
        checks++; if (bus.IMEM_REQ !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.IMEM_REQ); else passed++;
        checks++; if (bus.IMEM_ADDR !== 16'h0) $display("FAIL reset_addr: got %h want 0000", bus.IMEM_ADDR); else passed++;
        checks++; if (bus.IR_VALID !== 1'b0 || bus.IR_OUT !== 32'h0 || bus.PC_1 !== 16'h0)
            $display("FAIL reset_queue: got v=%b ir=%h pc1=%h want 0/0/0", bus.IR_VALID, bus.IR_OUT, bus.PC_1); else passed++;
        checks++; if (bus.FLUSH !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.FLUSH); else passed++;
        clear_inputs();
    endtask

    // Scenario 1: immediate ACKs, no stall; sequential addresses and data
    task automatic test_sequential();
        apply_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 16'(i))
                $display("FAIL seq_req%0d: got req=%b addr=%h want 1/%h", i, bus.IMEM_REQ, bus.IMEM_ADDR, 16'(i)); else passed++;
            bus.IMEM_ACK  = 1'b1;
            bus.IMEM_DATA = 32'hA000_0000 + 32'(i);
            step();
            bus.IMEM_ACK = 1'b0;
            checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_OUT !== 32'hA000_0000 + 32'(i) || bus.PC_1 !== 16'(i + 1))
                $display("FAIL seq_ir%0d: got v=%b ir=%h pc1=%h want 1/%h/%h", i, bus.IR_VALID, bus.IR_OUT, bus.PC_1,
                         32'hA000_0000 + 32'(i), 16'(i + 1)); else passed++;
            step();
        end
    endtask

    // Fill the queue under stall with an immediately answering memory
    task automatic fill_stalled();
        apply_reset();
        bus.STALL = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.IMEM_ACK  = bus.IMEM_REQ;
            bus.IMEM_DATA = 32'hA000_0000 + 32'(bus.IMEM_ADDR);
            step();
        end
        bus.IMEM_ACK = 1'b0;
    endtask

    // Scenario 2: stall fills exactly two entries, then drains in order
    task automatic test_stall();
        fill_stalled();
        checks++; if (bus.IMEM_REQ !== 1'b0) $display("FAIL stall_req: got %b want 0", bus.IMEM_REQ); else passed++;
        checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_OUT !== 32'hA000_0000)
            $display("FAIL stall_head: got v=%b ir=%h want 1/a0000000", bus.IR_VALID, bus.IR_OUT); else passed++;
        bus.STALL = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_OUT !== 32'hA000_0000 + 32'(k))
                $display("FAIL stall_drain%0d: got v=%b ir=%h want 1/%h", k, bus.IR_VALID, bus.IR_OUT, 32'hA000_0000 + 32'(k)); else passed++;
            bus.IMEM_ACK  = bus.IMEM_REQ;
            bus.IMEM_DATA = 32'hA000_0000 + 32'(bus.IMEM_ADDR);
            step();
        end
        bus.IMEM_ACK = 1'b0;
    endtask

    // Scenario 3: branch decode table, conditional taken and not taken
    task automatic test_cond_branch();
        fill_stalled();
        for (int k = 0; k < 7; k++) begin
            {bus.BR_VALID, bus.BS, bus.PS, bus.Z} = dec_in[k];
            #1;
            checks++; if (bus.MUX_C_SEL !== dec_exp[k])
                $display("FAIL decode%0d: got %0d want %0d", k, bus.MUX_C_SEL, dec_exp[k]); else passed++;
        end
        bus.BR_VALID = 1'b1; bus.BS = 2'b01; bus.PS = 1'b1; bus.Z = 1'b1; bus.BrA = 16'h0040;
        #1;
        checks++; if (bus.MUX_C_SEL !== 2'd1) $display("FAIL cond_sel: got %0d want 1", bus.MUX_C_SEL); else passed++;
        step();
        bus.BR_VALID = 1'b0;
        checks++; if (bus.FLUSH !== 1'b1 || bus.IR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b0)
            $display("FAIL cond_flush: got flush=%b v=%b req=%b want 1/0/0", bus.FLUSH, bus.IR_VALID, bus.IMEM_REQ); else passed++;
        step();
        checks++; if (bus.FLUSH !== 1'b0 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 16'h0040)
            $display("FAIL cond_target: got flush=%b req=%b addr=%h want 0/1/0040", bus.FLUSH, bus.IMEM_REQ, bus.IMEM_ADDR); else passed++;
        bus.BR_VALID = 1'b1; bus.Z = 1'b0;
        #1;
        checks++; if (bus.MUX_C_SEL !== 2'd0) $display("FAIL nt_sel: got %0d want 0", bus.MUX_C_SEL); else passed++;
        step();
        bus.BR_VALID = 1'b0;
        checks++; if (bus.FLUSH !== 1'b0 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 16'h0040)
            $display("FAIL nt_hold: got flush=%b req=%b addr=%h want 0/1/0040", bus.FLUSH, bus.IMEM_REQ, bus.IMEM_ADDR); else passed++;
        bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = 32'hCAFE_0040;
        step();
        bus.IMEM_ACK = 1'b0;
        checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_OUT !== 32'hCAFE_0040 || bus.PC_1 !== 16'h0041)
            $display("FAIL nt_push: got v=%b ir=%h pc1=%h want 1/cafe0040/0041", bus.IR_VALID, bus.IR_OUT, bus.PC_1); else passed++;
    endtask

    // Scenario 4: register jump while a request waits; enters REDIRECT
    task automatic test_redirect();
        bit found = 1'b0;
        apply_reset();
        for (int k = 0; k < 40 && !found; k++) begin
            if (bus.IMEM_REQ === 1'b1 && bus.IMEM_ADDR === 16'h0005) begin
                found = 1'b1;
            end else begin
                bus.IMEM_ACK  = bus.IMEM_REQ;
                bus.IMEM_DATA = 32'hA000_0000 + 32'(bus.IMEM_ADDR);
                step();
            end
        end
        bus.IMEM_ACK = 1'b0;
        checks++; if (!found) $display("FAIL redir_seek: got no request to 0005 want one within 40 cycles"); else passed++;
        step();
        bus.BR_VALID = 1'b1; bus.BS = 2'b10; bus.RAA = 16'h0123; bus.BrA = 16'h0777;
        #1;
        checks++; if (bus.MUX_C_SEL !== 2'd2) $display("FAIL redir_sel: got %0d want 2", bus.MUX_C_SEL); else passed++;
        step();
        bus.BR_VALID = 1'b0;
        checks++; if (bus.FLUSH !== 1'b1 || bus.IR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 16'h0005)
            $display("FAIL redir_hold: got flush=%b v=%b req=%b addr=%h want 1/0/1/0005",
                     bus.FLUSH, bus.IR_VALID, bus.IMEM_REQ, bus.IMEM_ADDR); else passed++;
        step();
        bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = 32'hA000_0005;
        step();
        bus.IMEM_ACK = 1'b0;
        checks++; if (bus.IR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b0)
            $display("FAIL redir_discard: got v=%b req=%b want 0/0", bus.IR_VALID, bus.IMEM_REQ); else passed++;
        step();
        checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 16'h0123 || bus.IR_VALID !== 1'b0)
            $display("FAIL redir_target: got req=%b addr=%h v=%b want 1/0123/0", bus.IMEM_REQ, bus.IMEM_ADDR, bus.IR_VALID); else passed++;
    endtask

    // Scenario 5: jump taken on the same edge as an ACK
    task automatic test_back_to_back();
        apply_reset();
        step();
        bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = 32'hA000_0000;
        bus.BR_VALID = 1'b1; bus.BS = 2'b11; bus.BrA = 16'h0200; bus.RAA = 16'h0999;
        #1;
        checks++; if (bus.MUX_C_SEL !== 2'd1) $display("FAIL b2b_sel: got %0d want 1", bus.MUX_C_SEL); else passed++;
        step();
        clear_inputs();
        checks++; if (bus.FLUSH !== 1'b1 || bus.IR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b0)
            $display("FAIL b2b_discard: got flush=%b v=%b req=%b want 1/0/0", bus.FLUSH, bus.IR_VALID, bus.IMEM_REQ); else passed++;
        step();
        checks++; if (bus.FLUSH !== 1'b0 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 16'h0200)
            $display("FAIL b2b_target: got flush=%b req=%b addr=%h want 0/1/0200", bus.FLUSH, bus.IMEM_REQ, bus.IMEM_ADDR); else passed++;
        bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = 32'h1234_5678;
        step();
        bus.IMEM_ACK = 1'b0;
        checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_OUT !== 32'h1234_5678 || bus.PC_1 !== 16'h0201)
            $display("FAIL b2b_push: got v=%b ir=%h pc1=%h want 1/12345678/0201", bus.IR_VALID, bus.IR_OUT, bus.PC_1); else passed++;
    endtask

    // Scenario 6: 4-bit PC wrap and reset while a request is outstanding
    task automatic test_wrap_reset();
        bus4.BR_VALID = 1'b0; bus4.BS = 2'b00; bus4.PS = 1'b0; bus4.Z = 1'b0;
        bus4.BrA = '0; bus4.RAA = '0; bus4.STALL = 1'b0;
        bus4.IMEM_ACK = 1'b0; bus4.IMEM_DATA = '0;
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        step();
        checks++; if (bus4.IMEM_REQ !== 1'b1 || bus4.IMEM_ADDR !== 4'hE)
            $display("FAIL wrap_reqE: got req=%b addr=%h want 1/e", bus4.IMEM_REQ, bus4.IMEM_ADDR); else passed++;
        bus4.IMEM_ACK = 1'b1; bus4.IMEM_DATA = 32'hA000_000E;
        step();
        bus4.IMEM_ACK = 1'b0;
        checks++; if (bus4.IR_VALID !== 1'b1 || bus4.IR_OUT !== 32'hA000_000E || bus4.PC_1 !== 4'hF)
            $display("FAIL wrap_irE: got v=%b ir=%h pc1=%h want 1/a000000e/f", bus4.IR_VALID, bus4.IR_OUT, bus4.PC_1); else passed++;
        step();
        checks++; if (bus4.IMEM_REQ !== 1'b1 || bus4.IMEM_ADDR !== 4'hF)
            $display("FAIL wrap_reqF: got req=%b addr=%h want 1/f", bus4.IMEM_REQ, bus4.IMEM_ADDR); else passed++;
        bus4.IMEM_ACK = 1'b1; bus4.IMEM_DATA = 32'hA000_000F;
        step();
        bus4.IMEM_ACK = 1'b0;
        checks++; if (bus4.IR_VALID !== 1'b1 || bus4.IR_OUT !== 32'hA000_000F || bus4.PC_1 !== 4'h0)
            $display("FAIL wrap_pc1: got v=%b ir=%h pc1=%h want 1/a000000f/0", bus4.IR_VALID, bus4.IR_OUT, bus4.PC_1); else passed++;
        bus4.STALL = 1'b1;
        step();
        checks++; if (bus4.IMEM_REQ !== 1'b1 || bus4.IMEM_ADDR !== 4'h0 || bus4.IR_VALID !== 1'b1)
            $display("FAIL wrap_req0: got req=%b addr=%h v=%b want 1/0/1", bus4.IMEM_REQ, bus4.IMEM_ADDR, bus4.IR_VALID); else passed++;
        rst4 = 1'b1;
        #1;
        checks++; if (bus4.IMEM_REQ !== 1'b0 || bus4.IR_VALID !== 1'b0 || bus4.IMEM_ADDR !== 4'h0)
            $display("FAIL wrap_async_rst: got req=%b v=%b addr=%h want 0/0/0", bus4.IMEM_REQ, bus4.IR_VALID, bus4.IMEM_ADDR); else passed++;
        bus4.STALL = 1'b0;
        bus4.IMEM_ACK = 1'b1; bus4.IMEM_DATA = 32'hDEAD_BEEF;
        step();
        rst4 = 1'b0;
        step();
        checks++; if (bus4.IMEM_REQ !== 1'b1 || bus4.IMEM_ADDR !== 4'hE || bus4.IR_VALID !== 1'b0)
            $display("FAIL wrap_late_ack: got req=%b addr=%h v=%b want 1/e/0", bus4.IMEM_REQ, bus4.IMEM_ADDR, bus4.IR_VALID); else passed++;
        bus4.IMEM_DATA = 32'hA000_000E;
        step();
        bus4.IMEM_ACK = 1'b0;
        checks++; if (bus4.IR_VALID !== 1'b1 || bus4.IR_OUT !== 32'hA000_000E || bus4.PC_1 !== 4'hF)
            $display("FAIL wrap_refetch: got v=%b ir=%h pc1=%h want 1/a000000e/f", bus4.IR_VALID, bus4.IR_OUT, bus4.PC_1); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_cond_branch();
        test_redirect();
        test_back_to_back();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and next-PC controller for the pipelined RISC CPU.
- Owns the PC register and drives the instruction-memory request handshake.
- Buffers up to two fetched instructions for decode.
- Resolves the execute-stage branch decision (BS/PS/Z) into the MUX C select, redirects the PC to BrA or RAA, and flushes wrong-path instructions.

Parameters:
- W, 16, PC / address width.
- IW, 32, instruction word width.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- BR_VALID  in  1  execute stage presents a resolved control instruction this cycle.
- BS  in  2  branch select: 00 none, 01 conditional, 10 jump to RAA, 11 jump to BrA.
- PS  in  1  conditional polarity.
- Z  in  1  zero flag from execute.
- BrA  in  W  branch target address.
- RAA  in  W  register jump target.
- STALL  in  1  decode cannot accept an instruction this cycle.
- IMEM_ACK  in  1  memory returns data for the outstanding request.
- IMEM_DATA  in  IW  instruction word, valid with IMEM_ACK.
- IMEM_REQ  out  1  fetch request, registered.
- IMEM_ADDR  out  W  fetch address, registered.
- IR_OUT  out  IW  head instruction to decode.
- IR_VALID  out  1  IR_OUT is valid.
- PC_1  out  W  fetch address+1 of the head instruction (link value).
- MUX_C_SEL  out  2  0 PC+1, 1 BrA, 2 RAA; combinational.
- FLUSH  out  1  kill younger in-flight decode/execute work, registered.

Behaviour:

Reset:
- PC=RESET_VECTOR.
- IMEM_REQ=0, IMEM_ADDR=0, IR_OUT=0, IR_VALID=0, PC_1=0, FLUSH=0.
- Queue empty; state FETCH.
- MUX_C_SEL=0 while RESET is high.
- Reset mid-request abandons the request. Any late IMEM_ACK arriving after reset with no request outstanding is ignored.

Branch decode (combinational, only while BR_VALID=1, otherwise MUX_C_SEL=0):
- BS=00: sel 0.
- BS=01: sel 1 if Z==PS, else 0.
- BS=10: sel 2.
- BS=11: sel 1.
- taken = BR_VALID & (MUX_C_SEL!=0).

Queue:
- 2-entry FIFO of {instruction, fetch address+1}.
- Head drives IR_OUT and PC_1; IR_VALID = count>0.
- Pop at a clock edge when IR_VALID & !STALL.
- Push on an accepted IMEM_ACK.
- Push and pop in the same cycle are both allowed.

Request launch:
- Condition: state FETCH, IMEM_REQ=0, !taken, and count minus pop is less than 2.
- Next edge: IMEM_REQ<=1, IMEM_ADDR<=PC, PC<=PC+1 (wraps modulo 2^W).
- At most one request is outstanding.
- IMEM_REQ and IMEM_ADDR are held stable until IMEM_ACK; IMEM_REQ drops on the ACK edge.
- Back-to-back launch is permitted on the cycle after ACK.
- Space is guaranteed at ACK because count<2 at launch.

States:
- FETCH
  - Normal operation; ACK data is pushed.
  - On taken: PC<=selected target (BrA or RAA), queue cleared, FLUSH<=1 for exactly one cycle.
  - If taken and a request is outstanding without ACK this cycle: go to REDIRECT.
  - If taken with ACK in the same cycle: the ACK data is discarded and the state stays FETCH.
- REDIRECT
  - IMEM_REQ is held until ACK; the ACK data is discarded.
  - No launch, queue stays empty, then return to FETCH.
  - A further taken branch here only overwrites PC and re-pulses FLUSH.

Priority: taken beats launch and push in the same cycle. Pop is irrelevant when taken, because the queue is cleared.

Latency:
- ACK at edge N with the queue empty gives IR_VALID=1 after edge N.
- Taken at edge N gives a request to the target after edge N+1 (no outstanding request) or after the ACK edge +1 (REDIRECT).

Decomposition:
- Shared package:
  - BS encodings (BS_NONE, BS_COND, BS_JREG, BS_JMP).
  - MUX C select constants (SEL_PC1, SEL_BRA, SEL_RAA).
  - fetch_state_t {FETCH, REDIRECT}.
- One sub-module: fetch_queue, the 2-deep FIFO with count, push, pop and clear.

Test Plan:
1. Reset release, STALL=0, ACK one cycle after each request with DATA=0xA0000000+addr.
   - IMEM_ADDR sequence 0,1,2,3.
   - IR_OUT matches each DATA; PC_1 = 1,2,3,4.
2. STALL held high for 6 cycles with immediate ACKs.
   - Exactly 2 instructions buffered; IMEM_REQ stays 0 afterwards; IR_OUT holds addr 0 data.
   - Release STALL: addresses 0,1,2 pop in order with none lost.
3. BR_VALID with BS=01, PS=1, Z=1, BrA=0x0040, no outstanding request.
   - MUX_C_SEL=1; FLUSH high one cycle; queue empties; next IMEM_ADDR=0x0040.
   - Repeat with Z=0: MUX_C_SEL=0, no redirect.
4. BS=10, RAA=0x0123 while a request to 0x0005 waits 3 cycles for ACK.
   - The 0x0005 data is discarded; IR_VALID stays 0; next IMEM_ADDR=0x0123.
5. Taken BS=11, BrA=0x0200 in the same cycle as ACK.
   - ACK data is not pushed; next request goes to 0x0200.
6. W=4 with PC at 0xF.
   - Fetch addr 0xF; next addr 0x0; PC_1 of the 0xF instruction = 0x0.
   - Assert RESET mid-request: IMEM_REQ=0 and IR_VALID=0 immediately; refetch from RESET_VECTOR.
